// File: rtl/niosii_mem_copy_pkg.sv
// Shared constants for the Nios II memory copy/fill master: FSM encoding,
// transfer modes and the Avalon byte-enable pattern.
package niosii_mem_copy_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_RD_REQ  = 3'd1;
  localparam state_t S_RD_WAIT = 3'd2;
  localparam state_t S_WR_REQ  = 3'd3;
  localparam state_t S_FINISH  = 3'd4;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/niosii_wrap_counter.sv
// Loadable word-address counter that wraps from DEPTH-1 back to 0.
// Exposes its next value so the owner can register a bus address from it.
module niosii_wrap_counter
  import niosii_mem_copy_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 12000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] count_next_o
);

  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = (count_q == ADDR_W'(DEPTH - 1)) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next_o = count_d;

endmodule

// File: rtl/niosii_mem_copy_master.sv
// Avalon-MM master that copies a word block between two address ranges or
// fills a range with a constant, one outstanding transfer at a time.
module niosii_mem_copy_master
  import niosii_mem_copy_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 12000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [31:0]       fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              abort_pend_q, abort_pend_d;
  logic              aborted_q, aborted_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, done_q, rd_q, wr_q;

  logic              src_load, dst_load, src_inc, dst_inc;
  logic [ADDR_W-1:0] src_next, dst_next;

  niosii_wrap_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_src_cnt (
    .clk_i        (clk),
    .rst_i        (reset),
    .load_i       (src_load),
    .load_val_i   (src_addr),
    .inc_i        (src_inc),
    .count_next_o (src_next)
  );

  niosii_wrap_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dst_cnt (
    .clk_i        (clk),
    .rst_i        (reset),
    .load_i       (dst_load),
    .load_val_i   (dst_addr),
    .inc_i        (dst_inc),
    .count_next_o (dst_next)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rem_d        = rem_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    words_d      = words_q;
    wdata_d      = wdata_q;
    src_load     = 1'b0;
    dst_load     = 1'b0;
    src_inc      = 1'b0;
    dst_inc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d       = mode;
          rem_d        = length;
          words_d      = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          src_load     = 1'b1;
          dst_load     = 1'b1;
          if (mode == MODE_FILL) wdata_d = fill_value;
          if (length == '0)            state_d = S_FINISH;
          else if (mode == MODE_FILL)  state_d = S_WR_REQ;
          else                         state_d = S_RD_REQ;
        end
      end
      // An abort seen during the read phase is remembered so the word
      // already being fetched is still written before stopping.
      S_RD_REQ: begin
        if (abort) abort_pend_d = 1'b1;
        if (!avm_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (avm_readdatavalid) begin
          wdata_d = avm_readdata;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (!avm_waitrequest) begin
          words_d = words_q + 1'b1;
          src_inc = 1'b1;
          dst_inc = 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == ADDR_W'(1)) begin
            state_d = S_FINISH;
          end else if (abort || abort_pend_q) begin
            state_d   = S_FINISH;
            aborted_d = 1'b1;
          end else if (mode_q == MODE_COPY) begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The address register follows whichever counter feeds the next request,
  // so it stays put while a request is stalled.
  always_comb begin
    addr_d = addr_q;
    if (state_d == S_RD_REQ)      addr_d = src_next;
    else if (state_d == S_WR_REQ) addr_d = dst_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_COPY;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      words_q      <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      words_q      <= words_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      busy_q       <= (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) ||
                      (state_d == S_WR_REQ);
      done_q       <= (state_d == S_FINISH);
      rd_q         <= (state_d == S_RD_REQ);
      wr_q         <= (state_d == S_WR_REQ);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign words_done     = words_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = BE_ALL;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_niosii_mem_copy_master.sv
// Directed bench for niosii_mem_copy_master: a table of commands run against
// a latency-1 memory model with configurable stalls, plus reset sequences.
module tb_niosii_mem_copy_master;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 12000;

  logic              clk = 1'b0;
  logic              reset, start, mode, abort;
  logic [ADDR_W-1:0] src_addr, dst_addr, length;
  logic [31:0]       fill_value;
  logic              busy, done, aborted;
  logic [ADDR_W-1:0] words_done, avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata, avm_readdata;
  logic              avm_readdatavalid, avm_waitrequest;

  niosii_mem_copy_master #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  function automatic int wrapi(input int a);
    return (a == DEPTH - 1) ? 0 : a + 1;
  endfunction

  // Memory model: decisions made on the falling edge for the next rising edge.
  logic [31:0] mem [0:DEPTH-1];
  int          stall_n = 0;
  int          stall_cnt = 0;
  logic        stalled = 1'b0;
  logic [63:0] held;
  logic        rd_pend = 1'b0;
  int          rd_addr = 0;
  int          bus_cyc = 0;
  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
  end

  always @(negedge clk) begin
    avm_readdatavalid = rd_pend;
    avm_readdata      = rd_pend ? mem[rd_addr] : 32'h0;
    rd_pend           = 1'b0;
    if (reset || !(avm_read || avm_write)) begin
      avm_waitrequest = 1'b0;
      stall_cnt       = 0;
      stalled         = 1'b0;
    end else begin
      bus_cyc++;
      if (stalled)
        chk("stall_hold", {14'h0, avm_read, avm_write, avm_address, avm_writedata}, held);
      if (stall_cnt < stall_n) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
        stalled = 1'b1;
        held    = {14'h0, avm_read, avm_write, avm_address, avm_writedata};
      end else begin
        avm_waitrequest = 1'b0;
        stall_cnt       = 0;
        stalled         = 1'b0;
        if (avm_read) begin
          rd_pend = 1'b1;
          rd_addr = int'(avm_address);
        end
        if (avm_write) begin
          mem[avm_address] = avm_writedata;
          wq_addr.push_back(int'(avm_address));
          wq_data.push_back(avm_writedata);
          wq_cyc.push_back(cyc);
        end
      end
    end
  end

  typedef struct {
    logic        mode;
    int          src, dst, len;
    logic [31:0] fill;
    int          stall, abort_at, restart_at;
    int          exp_done, exp_words;
    logic        exp_abort;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int dcyc;
    int sa, da;
    logic [31:0] ed;
    for (int a = 0; a < DEPTH; a++) mem[a] = pat(a);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    stall_n = v.stall;
    @(negedge clk);
    bus_cyc    = 0;
    mode       = v.mode;
    src_addr   = ADDR_W'(v.src);
    dst_addr   = ADDR_W'(v.dst);
    length     = ADDR_W'(v.len);
    fill_value = v.fill;
    start      = 1'b1;
    t0         = cyc;
    @(negedge clk);
    start = 1'b0;
    dcyc  = -1;
    for (int k = 1; k <= 400 && dcyc < 0; k++) begin
      start = (v.restart_at != 0 && k == v.restart_at);
      if (start) begin
        length = ADDR_W'(20); fill_value = ~v.fill; dst_addr = '0; mode = ~v.mode;
      end
      abort = (v.abort_at != 0 && k >= v.abort_at);
      if (k == 1) chk($sformatf("v%0d busy_c1", idx), 64'(busy), 64'(v.len != 0));
      if (done) dcyc = k;
      else @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    chk($sformatf("v%0d done_cycle", idx), 64'(dcyc), 64'(v.exp_done));
    chk($sformatf("v%0d words_done", idx), 64'(words_done), 64'(v.exp_words));
    chk($sformatf("v%0d aborted", idx), 64'(aborted), 64'(v.exp_abort));
    chk($sformatf("v%0d n_writes", idx), 64'(wq_addr.size()), 64'(v.exp_words));
    if (v.len == 0) chk($sformatf("v%0d bus_cycles", idx), 64'(bus_cyc), 64'(0));
    sa = v.src;
    da = v.dst;
    for (int i = 0; i < v.exp_words && i < wq_addr.size(); i++) begin
      ed = v.mode ? v.fill : pat(sa);
      chk($sformatf("v%0d wr%0d addr", idx, i), 64'(wq_addr[i]), 64'(da));
      chk($sformatf("v%0d wr%0d data", idx, i), 64'(wq_data[i]), 64'(ed));
      if (v.stall == 0)
        chk($sformatf("v%0d wr%0d cycle", idx, i), 64'(wq_cyc[i] - t0),
            64'(v.mode ? i + 1 : 3 * (i + 1)));
      sa = wrapi(sa);
      da = wrapi(da);
    end
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), 64'(done), 64'(0));
    chk($sformatf("v%0d busy_after", idx), 64'(busy), 64'(0));
    chk($sformatf("v%0d aborted_held", idx), 64'(aborted), 64'(v.exp_abort));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
    chk({tag, " aborted"}, 64'(aborted), 64'(0));
    chk({tag, " read"}, 64'(avm_read), 64'(0));
    chk({tag, " write"}, 64'(avm_write), 64'(0));
    chk({tag, " words"}, 64'(words_done), 64'(0));
    chk({tag, " addr"}, 64'(avm_address), 64'(0));
    chk({tag, " wdata"}, 64'(avm_writedata), 64'(0));
    chk({tag, " be"}, 64'(avm_byteenable), 64'(4'hF));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    //         mode  src    dst    len fill          stl ab rs done wds abt
    vecs[0] = '{1'b0, 16,    256,   4, 32'h0,        0, 0, 0, 13,  4, 1'b0};
    vecs[1] = '{1'b1, 0,     512,   3, 32'hDEADBEEF, 0, 0, 0, 4,   3, 1'b0};
    vecs[2] = '{1'b0, 48,    1280,  2, 32'h0,        2, 0, 0, 15,  2, 1'b0};
    vecs[3] = '{1'b1, 0,     11998, 4, 32'h12345678, 0, 0, 0, 5,   4, 1'b0};
    vecs[4] = '{1'b0, 5,     6,     0, 32'h0,        0, 0, 0, 1,   0, 1'b0};
    vecs[5] = '{1'b1, 0,     1536,  3, 32'hA5A5F00D, 0, 0, 2, 4,   3, 1'b0};
    vecs[6] = '{1'b0, 32,    1024,  8, 32'h0,        0, 4, 0, 7,   2, 1'b1};
    vecs[7] = '{1'b0, 11999, 80,    2, 32'h0,        0, 0, 0, 7,   2, 1'b0};
    vecs[8] = '{1'b1, 0,     1792,  2, 32'h0BADCAFE, 1, 0, 0, 5,   2, 1'b0};
    vecs[9] = '{1'b1, 0,     2048,  4, 32'h55AA55AA, 0, 2, 0, 3,   2, 1'b1};

    repeat (2) @(negedge clk);
    chk_reset_vals("rst_init");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while a fill write is being presented.
    stall_n = 0;
    @(negedge clk);
    mode = 1'b1; dst_addr = ADDR_W'(768); length = ADDR_W'(10);
    fill_value = 32'hFEEDFACE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_wr write", 64'(avm_write), 64'(1));
    chk("mid_wr words", 64'(words_done), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst write", 64'(avm_write), 64'(0));
    chk("post_rst busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
